// File: rtl/mem_responder_pkg.sv
// Shared definitions for the memory-side responder: bus command encodings,
// I/O address map and loader/run state encoding.
package mem_responder_pkg;

    localparam int DATA_W    = 16;
    localparam int ADDR_W    = 9;
    localparam int RAM_WORDS = 256;
    localparam int RAM_AW    = $clog2(RAM_WORDS);

    localparam logic [ADDR_W-1:0] LED_ADDR = 9'h100;
    localparam logic [ADDR_W-1:0] SW_ADDR  = 9'h140;

    typedef enum logic [1:0] {
        MNONE    = 2'b00,
        MREAD    = 2'b01,
        MWRITE   = 2'b10,
        MILLEGAL = 2'b11
    } mem_cmd_e;

    typedef enum logic {
        ST_LOAD = 1'b0,
        ST_RUN  = 1'b1
    } state_e;

    // Bit 8 of the bus address selects I/O space; below it lies the RAM.
    function automatic logic is_io_addr(input logic [ADDR_W-1:0] addr);
        return addr[ADDR_W-1];
    endfunction

endpackage

// File: rtl/mem_responder_ram_sync.sv
// Single-clock RAM with one write port and one enable-gated registered read
// port; the read register holds its value while the read enable is low.
module ram_sync
    import mem_responder_pkg::*;
#(
    parameter int DW = DATA_W,
    parameter int AW = RAM_AW
) (
    input  logic          clk,
    input  logic          i_we,
    input  logic [AW-1:0] i_waddr,
    input  logic [DW-1:0] i_wdata,
    input  logic          i_re,
    input  logic [AW-1:0] i_raddr,
    output logic [DW-1:0] o_rdata
);

    logic [DW-1:0] r_mem [2**AW];
    logic [DW-1:0] r_rdata;

    // NOTE: the array and its read register carry no reset so the storage maps
    // onto block RAM; anything that must read as zero is masked by the caller.
    always_ff @(posedge clk) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
        if (i_re) begin
            r_rdata <= r_mem[i_raddr];
        end
    end

    assign o_rdata = r_rdata;

endmodule

// File: rtl/mem_responder.sv
// CPU memory-bus responder: 256x16 RAM, LED/switch I/O, and a loader FSM that
// fills the RAM from a word stream before releasing the CPU via cpu_run.
module mem_responder
    import mem_responder_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic [ADDR_W-1:0] mem_addr,
    input  logic [1:0]        mem_cmd,
    input  logic [DATA_W-1:0] write_data,
    output logic [DATA_W-1:0] read_data,
    input  logic [7:0]        sw,
    output logic [7:0]        led,
    input  logic              load_valid,
    input  logic [DATA_W-1:0] load_data,
    input  logic              load_last,
    output logic              load_ready,
    output logic              cpu_run,
    output logic              bus_err
);

    state_e              r_state;
    state_e              w_state_next;
    logic [RAM_AW-1:0]   r_ptr;
    logic                r_load_ready;
    logic [7:0]          r_led;
    logic                r_bus_err;
    logic                r_rd_from_ram;
    logic [DATA_W-1:0]   r_io_rdata;

    logic                w_run;
    logic                w_xfer;
    logic                w_cpu_rd;
    logic                w_cpu_wr;
    logic                w_is_io;
    logic                w_is_led;
    logic                w_is_sw;
    logic                w_led_we;
    logic                w_err;
    logic [DATA_W-1:0]   w_io_rdata;
    logic                w_ram_we;
    logic [RAM_AW-1:0]   w_ram_waddr;
    logic [DATA_W-1:0]   w_ram_wdata;
    logic                w_ram_re;
    logic [DATA_W-1:0]   w_ram_rdata;

    // Bus commands are only honoured in RUN; during LOAD the loader owns the RAM.
    assign w_run    = (r_state == ST_RUN);
    assign w_xfer   = (r_state == ST_LOAD) && r_load_ready && load_valid;
    assign w_cpu_rd = w_run && (mem_cmd == MREAD);
    assign w_cpu_wr = w_run && (mem_cmd == MWRITE);
    assign w_is_io  = is_io_addr(mem_addr);
    assign w_is_led = (mem_addr == LED_ADDR);
    assign w_is_sw  = (mem_addr == SW_ADDR);

    always_comb begin
        w_state_next = r_state;
        if (w_xfer && (load_last || (r_ptr == RAM_AW'(RAM_WORDS - 1)))) begin
            w_state_next = ST_RUN;
        end
    end

    // NOTE: every combinational output is given a default before any branch,
    // so no path can leave one unassigned and infer a latch.
    always_comb begin
        w_led_we    = 1'b0;
        w_err       = 1'b0;
        w_io_rdata  = '0;
        w_ram_we    = 1'b0;
        w_ram_waddr = mem_addr[RAM_AW-1:0];
        w_ram_wdata = write_data;
        w_ram_re    = 1'b0;

        if (w_xfer) begin
            w_ram_we    = 1'b1;
            w_ram_waddr = r_ptr;
            w_ram_wdata = load_data;
        end

        if (w_cpu_wr) begin
            if (!w_is_io) begin
                w_ram_we = 1'b1;
            end else if (w_is_led) begin
                w_led_we = 1'b1;
            end else begin
                w_err = 1'b1;
            end
        end

        if (w_cpu_rd) begin
            if (!w_is_io) begin
                w_ram_re = 1'b1;
            end else if (w_is_sw) begin
                w_io_rdata = {8'h00, sw};
            end else if (w_is_led) begin
                w_io_rdata = {8'h00, r_led};
            end else begin
                w_err = 1'b1;
            end
        end

        if (w_run && (mem_cmd == MILLEGAL)) begin
            w_err = 1'b1;
        end
    end

    // NOTE: state is updated with non-blocking assignments so every register
    // samples the pre-edge values of its neighbours.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state       <= ST_LOAD;
            r_ptr         <= '0;
            r_load_ready  <= 1'b0;
            r_led         <= '0;
            r_bus_err     <= 1'b0;
            r_rd_from_ram <= 1'b0;
            r_io_rdata    <= '0;
        end else begin
            r_state      <= w_state_next;
            r_load_ready <= (w_state_next == ST_LOAD);
            if (w_xfer && (r_ptr != RAM_AW'(RAM_WORDS - 1))) begin
                r_ptr <= r_ptr + 1'b1;
            end
            if (w_led_we) begin
                r_led <= write_data[7:0];
            end
            if (w_err) begin
                r_bus_err <= 1'b1;
            end
            if (w_cpu_rd) begin
                r_rd_from_ram <= !w_is_io;
                r_io_rdata    <= w_io_rdata;
            end
        end
    end

    ram_sync #(
        .DW (DATA_W),
        .AW (RAM_AW)
    ) u_ram (
        .clk     (clk),
        .i_we    (w_ram_we),
        .i_waddr (w_ram_waddr),
        .i_wdata (w_ram_wdata),
        .i_re    (w_ram_re),
        .i_raddr (mem_addr[RAM_AW-1:0]),
        .o_rdata (w_ram_rdata)
    );

    // The RAM read register is unreset, so read_data only selects it after a RAM read.
    assign read_data  = r_rd_from_ram ? w_ram_rdata : r_io_rdata;
    assign led        = r_led;
    assign bus_err    = r_bus_err;
    assign load_ready = r_load_ready;
    assign cpu_run    = w_run;

endmodule

// File: tb/tb_mem_responder.sv
// Randomized self-checking bench for mem_responder against a behavioural
// memory/loader model kept in plain arrays and flags.
module tb_mem_responder;
    import mem_responder_pkg::*;

    logic        clk = 1'b0;
    logic        reset;
    logic [8:0]  mem_addr;
    logic [1:0]  mem_cmd;
    logic [15:0] write_data;
    logic [15:0] read_data;
    logic [7:0]  sw;
    logic [7:0]  led;
    logic        load_valid;
    logic [15:0] load_data;
    logic        load_last;
    logic        load_ready;
    logic        cpu_run;
    logic        bus_err;

    always #5 clk = ~clk;

    mem_responder dut (
        .clk        (clk),
        .reset      (reset),
        .mem_addr   (mem_addr),
        .mem_cmd    (mem_cmd),
        .write_data (write_data),
        .read_data  (read_data),
        .sw         (sw),
        .led        (led),
        .load_valid (load_valid),
        .load_data  (load_data),
        .load_last  (load_last),
        .load_ready (load_ready),
        .cpu_run    (cpu_run),
        .bus_err    (bus_err)
    );

    int checks   = 0;
    int failures = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // Reference model: RAM contents with a known flag, loader progress, I/O state.
    logic [15:0] ram_m   [256];
    bit          known_m [256];
    bit          run_m;
    bit          ready_m;
    int          ptr_m;
    logic [7:0]  led_m;
    bit          err_m;
    logic [15:0] rd_m;
    bit          rd_known_m;
    bit          xfer_m;

    task automatic model_reset();
        run_m      = 0;
        ready_m    = 0;
        ptr_m      = 0;
        led_m      = 8'h00;
        err_m      = 0;
        rd_m       = 16'h0000;
        rd_known_m = 1;
        xfer_m     = 0;
    endtask

    task automatic model_edge();
        int a;
        a = int'(mem_addr);
        xfer_m = 0;
        if (!run_m) begin
            if (load_valid && ready_m) begin
                xfer_m         = 1;
                ram_m[ptr_m]   = load_data;
                known_m[ptr_m] = 1;
                if (load_last || ptr_m == 255) run_m = 1;
                else ptr_m++;
            end
            ready_m = !run_m;
        end else begin
            if (mem_cmd == 2'b10) begin
                if (a < 256) begin
                    ram_m[a]   = write_data;
                    known_m[a] = 1;
                end else if (a == 'h100) begin
                    led_m = write_data[7:0];
                end else begin
                    err_m = 1;
                end
            end else if (mem_cmd == 2'b01) begin
                if (a < 256) begin
                    rd_m       = ram_m[a];
                    rd_known_m = known_m[a];
                end else if (a == 'h140) begin
                    rd_m       = {8'h00, sw};
                    rd_known_m = 1;
                end else if (a == 'h100) begin
                    rd_m       = {8'h00, led_m};
                    rd_known_m = 1;
                end else begin
                    rd_m       = 16'h0000;
                    rd_known_m = 1;
                    err_m      = 1;
                end
            end else if (mem_cmd == 2'b11) begin
                err_m = 1;
            end
        end
    endtask

    task automatic compare_outputs();
        check("cpu_run", {31'b0, cpu_run}, {31'b0, run_m});
        check("load_ready", {31'b0, load_ready}, {31'b0, ready_m});
        check("led", {24'b0, led}, {24'b0, led_m});
        check("bus_err", {31'b0, bus_err}, {31'b0, err_m});
        if (rd_known_m) check("read_data", {16'b0, read_data}, {16'b0, rd_m});
    endtask

    // Inputs are applied at the falling edge; the model steps on the rising edge.
    task automatic cycle();
        @(posedge clk);
        if (reset) model_edge();
        @(negedge clk);
        compare_outputs();
    endtask

    task automatic set_bus(input logic [1:0] cmd, input logic [8:0] addr, input logic [15:0] wd);
        mem_cmd    = cmd;
        mem_addr   = addr;
        write_data = wd;
    endtask

    task automatic rand_bus(input bit allow_err);
        int r;
        r = $urandom_range(0, 99);
        if (r < 40)                    mem_cmd = 2'b01;
        else if (r < 75)               mem_cmd = 2'b10;
        else if (r < 90 || !allow_err) mem_cmd = 2'b00;
        else                           mem_cmd = 2'b11;
        r = $urandom_range(0, 99);
        if (r < 30)      mem_addr = 9'($urandom_range(0, 7));
        else if (r < 60) mem_addr = 9'($urandom_range(0, 255));
        else if (r < 72) mem_addr = 9'h100;
        else if (r < 84) mem_addr = 9'h140;
        else if (allow_err) mem_addr = 9'(256 + $urandom_range(0, 255));
        else             mem_addr = 9'h100;
        if (!allow_err && mem_cmd == 2'b10 && mem_addr == 9'h140) mem_addr = 9'h100;
        write_data = 16'($urandom);
        sw         = 8'($urandom);
        load_valid = 1'($urandom);
        load_data  = 16'($urandom);
        load_last  = 1'($urandom);
    endtask

    logic [15:0] words [3];

    initial begin
        words[0] = 16'hD005;
        words[1] = 16'h6020;
        words[2] = 16'hE000;
        for (int i = 0; i < 256; i++) known_m[i] = 0;

        reset      = 1'b0;
        set_bus(2'b00, 9'h000, 16'h0000);
        sw         = 8'h00;
        load_valid = 1'b0;
        load_data  = 16'h0000;
        load_last  = 1'b0;
        model_reset();
        repeat (2) @(negedge clk);
        compare_outputs();
        reset = 1'b1;

        // Three-word load with random gaps and bus traffic that LOAD must ignore.
        begin
            int idx;
            idx = 0;
            for (int c = 0; c < 60 && !run_m; c++) begin
                rand_bus(1);
                load_valid = ($urandom_range(0, 9) < 7);
                load_data  = words[idx];
                load_last  = (idx == 2);
                cycle();
                if (xfer_m) idx++;
            end
        end
        check("load3_run", {31'b0, cpu_run}, 32'd1);
        load_valid = 1'b0;

        for (int i = 0; i < 3; i++) begin
            set_bus(2'b01, 9'(i), 16'h0000);
            cycle();
            check($sformatf("load3_word%0d", i), {16'b0, read_data}, {16'b0, words[i]});
        end

        set_bus(2'b10, 9'h005, 16'h1234);
        cycle();
        set_bus(2'b01, 9'h005, 16'h0000);
        cycle();
        check("wr_rd_1234", {16'b0, read_data}, 32'h1234);
        set_bus(2'b00, 9'h005, 16'hFFFF);
        repeat (2) cycle();
        check("hold_1234", {16'b0, read_data}, 32'h1234);

        set_bus(2'b10, 9'h100, 16'hFFA5);
        cycle();
        check("led_a5", {24'b0, led}, 32'hA5);
        sw = 8'h3C;
        set_bus(2'b01, 9'h140, 16'h0000);
        cycle();
        check("sw_read", {16'b0, read_data}, 32'h003C);
        set_bus(2'b01, 9'h100, 16'h0000);
        cycle();
        check("led_read", {16'b0, read_data}, 32'h00A5);
        check("no_err_yet", {31'b0, bus_err}, 32'd0);

        set_bus(2'b10, 9'h140, 16'h0077);
        cycle();
        check("sw_write_err", {31'b0, bus_err}, 32'd1);
        check("sw_write_led", {24'b0, led}, 32'hA5);
        set_bus(2'b11, 9'h000, 16'h0000);
        cycle();
        set_bus(2'b01, 9'h1FF, 16'h0000);
        cycle();
        check("rd_unmapped", {16'b0, read_data}, 32'h0000);
        check("err_sticky", {31'b0, bus_err}, 32'd1);

        for (int c = 0; c < 200; c++) begin
            rand_bus(1);
            cycle();
        end

        // Asynchronous reset in the middle of the high phase.
        @(posedge clk);
        #2 reset = 1'b0;
        #1 model_reset();
        check("arst_cpu_run", {31'b0, cpu_run}, 32'd0);
        check("arst_led", {24'b0, led}, 32'd0);
        check("arst_read_data", {16'b0, read_data}, 32'd0);
        check("arst_bus_err", {31'b0, bus_err}, 32'd0);
        @(negedge clk);
        compare_outputs();
        reset = 1'b1;

        // Reload with stalls; bus writes during LOAD must not touch RAM or LED.
        for (int c = 0; c < 6; c++) begin
            rand_bus(1);
            load_valid = 1'b0;
            cycle();
        end
        check("load_ready_up", {31'b0, load_ready}, 32'd1);
        for (int c = 0; c < 60 && !run_m; c++) begin
            rand_bus(1);
            load_valid = ($urandom_range(0, 1) == 1);
            load_last  = (ptr_m == 2);
            cycle();
        end
        for (int c = 0; c < 150; c++) begin
            rand_bus(0);
            cycle();
        end

        // Full 256-word load without load_last.
        @(negedge clk);
        reset = 1'b0;
        model_reset();
        @(negedge clk);
        compare_outputs();
        reset = 1'b1;
        for (int c = 0; c < 1500 && !run_m; c++) begin
            rand_bus(1);
            load_valid = ($urandom_range(0, 3) != 0);
            load_last  = 1'b0;
            cycle();
        end
        check("load256_run", {31'b0, cpu_run}, 32'd1);
        check("load256_ready", {31'b0, load_ready}, 32'd0);
        for (int c = 0; c < 300; c++) begin
            rand_bus(0);
            cycle();
        end
        for (int c = 0; c < 100; c++) begin
            rand_bus(1);
            cycle();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "time limit");
    end

endmodule
